// File: rtl/interface_pkg.sv
// Shared AHB encodings and the line-fill FSM state type used by the fetch master.
package interface_pkg;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'b000,
    BURST_INCR   = 3'b001,
    BURST_WRAP4  = 3'b010,
    BURST_INCR4  = 3'b011
  } burst_types_e;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } trans_types_e;

  // A four-word line occupies one 16-byte aligned block.
  localparam logic [31:0] WRAP4_BOUNDARY_MASK = 32'hFFFF_FFF0;
  localparam logic [2:0]  HSIZE_WORD          = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    ADDR0,
    BURST,
    DRAIN,
    DONE,
    ERR
  } fetch_state_e;

endpackage

// File: rtl/ahb_wrap_fetch_master_if.sv
// AHB-Lite read-only bus bundle between the fetch master and its slave.
interface ahb_wrap_fetch_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic [2:0]        hburst;
  logic [2:0]        hsize;
  logic              hwrite;
  logic [DATA_W-1:0] hrdata;
  logic              hready;
  logic              hresp;

  modport master (
    output haddr, htrans, hburst, hsize, hwrite,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  haddr, htrans, hburst, hsize, hwrite,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb_wrap_addr_gen.sv
// Beat address sequencer: 16-byte base plus a word offset that wraps (critical
// word first, AHB_FETCH_CRITICAL_WORD_FIRST_EN) or counts linearly from the base.
module ahb_wrap_addr_gen
  import interface_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              advance,
  output logic [ADDR_W-1:0] base,
  output logic [1:0]        offset,
  output logic [ADDR_W-1:0] cur_addr
);

  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(~WRAP4_BOUNDARY_MASK);

  logic [ADDR_W-1:0] base_reg;
  logic [1:0]        offset_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      base_reg   <= '0;
      offset_reg <= '0;
    end else if (load) begin
      base_reg   <= load_addr & BASE_MASK;
`ifdef AHB_FETCH_CRITICAL_WORD_FIRST_EN
      offset_reg <= load_addr[3:2];
`else
      offset_reg <= 2'd0;
`endif
    end else if (advance) begin
`ifndef AHB_FETCH_CRITICAL_WORD_FIRST_EN
      // Linear increment carries out of the block instead of wrapping.
      if (offset_reg == 2'd3) begin
        base_reg <= base_reg + ADDR_W'(16);
      end
`endif
      offset_reg <= offset_reg + 2'd1;
    end
  end

  assign base     = base_reg;
  assign offset   = offset_reg;
  assign cur_addr = base_reg | ADDR_W'({offset_reg, 2'b00});

endmodule

// File: rtl/ahb_wrap_fetch_master.sv
// Four-beat AHB line-fill master; burst type and start word selected by
// AHB_FETCH_CRITICAL_WORD_FIRST_EN (WRAP4 from miss word) or INCR4 from base.
module ahb_wrap_fetch_master
  import interface_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  output logic                  line_valid,
  output logic [ADDR_W-1:0]     line_addr,
  output logic [4*DATA_W-1:0]   line_data,
  output logic                  err,
  ahb_wrap_fetch_master_if.master ahb
);

`ifdef AHB_FETCH_CRITICAL_WORD_FIRST_EN
  localparam burst_types_e START_BURST = BURST_WRAP4;
`else
  localparam burst_types_e START_BURST = BURST_INCR4;
`endif

  fetch_state_e      state_reg;
  trans_types_e      htrans_reg;
  burst_types_e      hburst_reg;
  logic              req_ready_reg;
  logic              line_valid_reg;
  logic              err_reg;
  logic [ADDR_W-1:0] line_addr_reg;
  logic [1:0]        addr_cnt_reg;
  logic              dp_valid_reg;
  logic [1:0]        dp_slot_reg;

  logic              ag_load;
  logic              ag_advance;
  logic [ADDR_W-1:0] ag_base;
  logic [1:0]        ag_offset;
  logic [ADDR_W-1:0] ag_cur_addr;
  logic              dp_error;

  assign ag_load    = (state_reg == IDLE) && req_valid;
  assign ag_advance = ahb.hready &&
                      ((state_reg == ADDR0) ||
                       ((state_reg == BURST) && (addr_cnt_reg != 2'd3)));
  // First cycle of the two-cycle ERROR response terminates the burst.
  assign dp_error   = dp_valid_reg && ahb.hresp && !ahb.hready;

  ahb_wrap_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (ag_load),
    .load_addr (req_addr),
    .advance   (ag_advance),
    .base      (ag_base),
    .offset    (ag_offset),
    .cur_addr  (ag_cur_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      htrans_reg     <= TRANS_IDLE;
      hburst_reg     <= BURST_SINGLE;
      req_ready_reg  <= 1'b1;
      line_valid_reg <= 1'b0;
      err_reg        <= 1'b0;
      line_addr_reg  <= '0;
      addr_cnt_reg   <= 2'd0;
      dp_valid_reg   <= 1'b0;
      dp_slot_reg    <= 2'd0;
    end else begin
      line_valid_reg <= 1'b0;
      err_reg        <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            state_reg     <= ADDR0;
            htrans_reg    <= TRANS_NONSEQ;
            hburst_reg    <= START_BURST;
            req_ready_reg <= 1'b0;
            addr_cnt_reg  <= 2'd0;
          end
        end
        ADDR0: begin
          if (ahb.hready) begin
            state_reg    <= BURST;
            htrans_reg   <= TRANS_SEQ;
            addr_cnt_reg <= 2'd1;
            dp_valid_reg <= 1'b1;
            dp_slot_reg  <= ag_offset;
          end
        end
        BURST: begin
          if (dp_error) begin
            state_reg    <= ERR;
            htrans_reg   <= TRANS_IDLE;
            dp_valid_reg <= 1'b0;
            err_reg      <= 1'b1;
          end else if (ahb.hready) begin
            dp_valid_reg <= 1'b1;
            dp_slot_reg  <= ag_offset;
            if (addr_cnt_reg == 2'd3) begin
              state_reg  <= DRAIN;
              htrans_reg <= TRANS_IDLE;
            end else begin
              addr_cnt_reg <= addr_cnt_reg + 2'd1;
            end
          end
        end
        DRAIN: begin
          if (dp_error) begin
            state_reg    <= ERR;
            dp_valid_reg <= 1'b0;
            err_reg      <= 1'b1;
          end else if (ahb.hready) begin
            state_reg      <= DONE;
            dp_valid_reg   <= 1'b0;
            line_valid_reg <= 1'b1;
            line_addr_reg  <= ag_base;
          end
        end
        DONE, ERR: begin
          state_reg     <= IDLE;
          req_ready_reg <= 1'b1;
        end
        default: begin
          state_reg     <= IDLE;
          htrans_reg    <= TRANS_IDLE;
          req_ready_reg <= 1'b1;
          dp_valid_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Each line slot captures the word whose address phase named that slot.
  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    logic [DATA_W-1:0] word_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        word_reg <= '0;
      end else if (dp_valid_reg && ahb.hready && (dp_slot_reg == 2'(gi))) begin
        word_reg <= ahb.hrdata;
      end
    end
    assign line_data[gi*DATA_W +: DATA_W] = word_reg;
  end

  assign req_ready  = req_ready_reg;
  assign line_valid = line_valid_reg;
  assign line_addr  = line_addr_reg;
  assign err        = err_reg;

  assign ahb.haddr  = ag_cur_addr;
  assign ahb.htrans = htrans_reg;
  assign ahb.hburst = hburst_reg;
  assign ahb.hsize  = HSIZE_WORD;
  assign ahb.hwrite = 1'b0;

endmodule
